// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: M-extension divide opcodes, divider FSM states and
// the most negative 32-bit integer.
package rv32_pkg;

    localparam int RV_XLEN = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [RV_XLEN-1:0] MIN_INT = {1'b1, {(RV_XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } div_state_t;

endpackage

// File: rtl/rv32_div_step.sv
// One combinational restoring-division iteration: shift the next dividend bit
// into the partial remainder and subtract the divisor if it fits.
module rv32_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;
    logic          fits;

    assign shifted = {rem_in[XLEN-1:0], quo_in[XLEN-1]};
    assign trial   = shifted - {1'b0, divisor};
    // A set top bit in rem_in would make the shifted value exceed any divisor.
    assign fits    = ~trial[XLEN] | rem_in[XLEN];

    assign rem_out = fits ? trial : shifted;
    assign quo_out = {quo_in[XLEN-2:0], fits};

endmodule

// File: rtl/rv32_mux2.sv
// Generic n-bit 2:1 mux: sel=0 picks d0, sel=1 picks d1.
module rv32_mux2 #(
    parameter int N = 32
) (
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic         sel,
    output logic [N-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/rv32_div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): one restoring step per cycle,
// with a single-cycle fast path for divide-by-zero and signed overflow.
module rv32_div_unit
    import rv32_pkg::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CW      = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state, state_next;
    logic [XLEN:0]   rem_q, rem_next;
    logic [XLEN-1:0] quo_q, quo_next, div_q;
    logic [CW-1:0]   cnt_q;
    logic            sel_q, neg_quo_q, neg_rem_q;

    logic            accept, is_signed, div_zero, ovf, fast, last_step;
    logic [XLEN-1:0] a_mag, b_mag, fast_quo, fast_rem, fin_quo, fin_rem;
    logic [XLEN-1:0] mux_d0, mux_d1, mux_y;
    logic            mux_sel;

    assign accept    = (state != CALC) && start && !flush;
    assign is_signed = ~op[0];
    assign div_zero  = (rs2 == '0);
    assign ovf       = is_signed && (rs1 == MIN_VAL) && (rs2 == '1);
    assign fast      = div_zero || ovf;
    assign last_step = (state == CALC) && (cnt_q == LAST);

    // Negating MIN_INT leaves it as unsigned 2^(XLEN-1), which is the magnitude we want.
    assign a_mag = (is_signed && rs1[XLEN-1]) ? -rs1 : rs1;
    assign b_mag = (is_signed && rs2[XLEN-1]) ? -rs2 : rs2;

    assign fast_quo = div_zero ? '1  : MIN_VAL;
    assign fast_rem = div_zero ? rs1 : '0;

    rv32_div_step #(.XLEN(XLEN)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (div_q),
        .rem_out (rem_next),
        .quo_out (quo_next)
    );

    assign fin_quo = neg_quo_q ? -quo_next : quo_next;
    assign fin_rem = neg_rem_q ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];

    assign mux_d0  = (state == CALC) ? fin_quo : fast_quo;
    assign mux_d1  = (state == CALC) ? fin_rem : fast_rem;
    assign mux_sel = (state == CALC) ? sel_q   : op[1];

    rv32_mux2 #(.N(XLEN)) u_sel (
        .d0  (mux_d0),
        .d1  (mux_d1),
        .sel (mux_sel),
        .y   (mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, FIN: state_next = accept ? (fast ? FIN : CALC) : IDLE;
            CALC:      if (last_step) state_next = FIN;
            default:   state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            sel_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result    <= '0;
        end else if (accept) begin
            rem_q     <= '0;
            quo_q     <= a_mag;
            div_q     <= b_mag;
            cnt_q     <= '0;
            sel_q     <= op[1];
            neg_quo_q <= is_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
            neg_rem_q <= is_signed && rs1[XLEN-1];
            if (fast) result <= mux_y;
        end else if (state == CALC && !flush) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= cnt_q + CW'(1);
            if (last_step) result <= mux_y;
        end
    end

    assign busy = (state == CALC);
    assign done = (state == FIN);

endmodule
